// File: rtl/mem_write_buffer.sv
// mem_write_buffer
// ----------------
// Sits between the AHB DMA slave memory-write port and the SRAM macro.
// Every cycle with mem_write_flag high is captured into a DEPTH-entry
// circular buffer of {addr, data}. The buffer drains toward the SRAM through
// a request/grant handshake, so SRAM stalls during a burst are absorbed.
// Status outputs give the fill level, full/empty, a sticky overflow flag
// (a write was dropped because the buffer was full) and a wrapping count of
// writes retired to the SRAM.
//
// Ports
//   HCLK            clock, all state changes on the rising edge
//   HRESETn         asynchronous active-low reset
//   mem_WR_addr     write address from the slave
//   mem_write_flag  write strobe, one write per high cycle
//   HWDATA_toMem    write data from the slave
//   sram_req        head entry valid toward the SRAM
//   sram_addr       head entry address (0 while empty)
//   sram_wdata      head entry data (0 while empty)
//   sram_gnt        SRAM accepts the head entry this cycle
//   i_clr           synchronous clear of o_overflow and o_words_written
//   o_level         occupied entries, 0..DEPTH
//   o_full          o_level == DEPTH
//   o_empty         o_level == 0
//   o_overflow      sticky, a write was dropped
//   o_words_written writes retired to the SRAM, wraps at 16 bits
module mem_write_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [ADDR_W-1:0]          mem_WR_addr,
  input  logic                       mem_write_flag,
  input  logic [DATA_W-1:0]          HWDATA_toMem,
  output logic                       sram_req,
  output logic [ADDR_W-1:0]          sram_addr,
  output logic [DATA_W-1:0]          sram_wdata,
  input  logic                       sram_gnt,
  input  logic                       i_clr,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_overflow,
  output logic [15:0]                o_words_written
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  logic [ADDR_W-1:0] r_addrMem [DEPTH];
  logic [DATA_W-1:0] r_dataMem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;
  logic [15:0]       r_wordsWritten;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_level == FULL_LEVEL);
  assign w_empty = (r_level == '0);

  // A grant with nothing queued is ignored. When full, a same-cycle pop frees
  // the head slot, so the incoming write is still accepted; at full wr_ptr
  // equals rd_ptr, and the old head leaves on the same edge it is overwritten.
  assign w_pop  = !w_empty && sram_gnt;
  assign w_push = mem_write_flag && (!w_full || w_pop);
  assign w_drop = mem_write_flag && w_full && !w_pop;

  // Storage array carries no reset; its contents are only observed through
  // the empty-masked read port below.
  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_addrMem[r_wrPtr] <= mem_WR_addr;
      r_dataMem[r_wrPtr] <= HWDATA_toMem;
    end
  end

  // Pointers, level and status counters. Pointers wrap naturally because
  // DEPTH is a power of two. Clear wins over a same-cycle drop or retire.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wrPtr        <= '0;
      r_rdPtr        <= '0;
      r_level        <= '0;
      r_overflow     <= 1'b0;
      r_wordsWritten <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_W'(1);
      end
      if (i_clr) begin
        r_overflow     <= 1'b0;
        r_wordsWritten <= '0;
      end else begin
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if (w_pop) begin
          r_wordsWritten <= r_wordsWritten + 16'd1;
        end
      end
    end
  end

  // Head entry is masked to zero while empty so the SRAM side reads 0 out of
  // reset (and immediately on an asynchronous reset) despite the unreset array.
  assign sram_req   = !w_empty;
  assign sram_addr  = w_empty ? '0 : r_addrMem[r_rdPtr];
  assign sram_wdata = w_empty ? '0 : r_dataMem[r_rdPtr];

  assign o_level         = r_level;
  assign o_full          = w_full;
  assign o_empty         = w_empty;
  assign o_overflow      = r_overflow;
  assign o_words_written = r_wordsWritten;

endmodule

// File: tb/tb_mem_write_buffer.sv
// tb_mem_write_buffer
// -------------------
// Self-checking bench for mem_write_buffer (DEPTH 8, 32-bit addr/data).
// A reference model runs on the falling edge: it holds the expected queue of
// {addr, data} pairs, the expected level, overflow flag and retired count.
// Accepted writes are pushed into the queue when they are driven; every
// grant seen on a valid head pops the queue and compares the SRAM-side pair.
// Directed checks against fixed constants cover the named scenarios.
module tb_mem_write_buffer;

  localparam int DEPTH = 8;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] mem_WR_addr;
  logic        mem_write_flag;
  logic [31:0] HWDATA_toMem;
  logic        sram_req;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_gnt;
  logic        i_clr;
  logic [3:0]  o_level;
  logic        o_full;
  logic        o_empty;
  logic        o_overflow;
  logic [15:0] o_words_written;

  mem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .HCLK            (HCLK),
    .HRESETn         (HRESETn),
    .mem_WR_addr     (mem_WR_addr),
    .mem_write_flag  (mem_write_flag),
    .HWDATA_toMem    (HWDATA_toMem),
    .sram_req        (sram_req),
    .sram_addr       (sram_addr),
    .sram_wdata      (sram_wdata),
    .sram_gnt        (sram_gnt),
    .i_clr           (i_clr),
    .o_level         (o_level),
    .o_full          (o_full),
    .o_empty         (o_empty),
    .o_overflow      (o_overflow),
    .o_words_written (o_words_written)
  );

  // 10 ns clock
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int checkCount = 0;
  int passCount  = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge.
  task automatic applyStimulus(input logic flag, input logic [31:0] addr,
                               input logic [31:0] data, input logic gnt,
                               input logic clr);
    @(posedge HCLK);
    #1;
    mem_write_flag = flag;
    mem_WR_addr    = addr;
    HWDATA_toMem   = data;
    sram_gnt       = gnt;
    i_clr          = clr;
  endtask

  task automatic idleCycle(input logic gnt);
    applyStimulus(1'b0, 32'h0, 32'h0, gnt, 1'b0);
  endtask

  // Reference model state; values describe what the DUT should show this cycle.
  logic [63:0] sbQueue[$];
  int          mLevel    = 0;
  logic        mOverflow = 1'b0;
  logic [15:0] mWords    = 16'd0;

  // Falling-edge model: compare current DUT state, then advance the model by
  // what the next rising edge will do with the inputs now being driven.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      sbQueue.delete();
      mLevel    = 0;
      mOverflow = 1'b0;
      mWords    = 16'd0;
    end else begin
      logic        mPop;
      logic        mPush;
      logic [63:0] head;
      checkOutput("req",      {63'd0, sram_req},        {63'd0, (mLevel != 0)});
      checkOutput("level",    {60'd0, o_level},         64'(mLevel));
      checkOutput("full",     {63'd0, o_full},          {63'd0, (mLevel == DEPTH)});
      checkOutput("empty",    {63'd0, o_empty},         {63'd0, (mLevel == 0)});
      checkOutput("overflow", {63'd0, o_overflow},      {63'd0, mOverflow});
      checkOutput("words",    {48'd0, o_words_written}, {48'd0, mWords});
      mPop  = (mLevel != 0) && sram_gnt;
      mPush = mem_write_flag && ((mLevel < DEPTH) || mPop);
      if (mPop) begin
        head = sbQueue.pop_front();
        checkOutput("sram_pair", {sram_addr, sram_wdata}, head);
      end
      if (mPush) begin
        sbQueue.push_back({mem_WR_addr, HWDATA_toMem});
      end
      if (mPush && !mPop) mLevel = mLevel + 1;
      else if (mPop && !mPush) mLevel = mLevel - 1;
      if (i_clr) begin
        mOverflow = 1'b0;
        mWords    = 16'd0;
      end else begin
        if (mem_write_flag && (mLevel == DEPTH) && !mPop && !mPush) mOverflow = 1'b1;
        if (mPop) mWords = mWords + 16'd1;
      end
    end
  end

  // Single write with grant high; the pair must show up exactly one cycle
  // after the push cycle and be gone the cycle after.
  task automatic singleWrite(input string tag);
    applyStimulus(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput({tag, "_no_write_through"}, {63'd0, sram_req}, 64'd0);
    idleCycle(1'b1);
    @(negedge HCLK);
    checkOutput({tag, "_req"},   {63'd0, sram_req}, 64'd1);
    checkOutput({tag, "_addr"},  {32'd0, sram_addr}, 64'h0000_0100);
    checkOutput({tag, "_wdata"}, {32'd0, sram_wdata}, 64'hDEAD_BEEF);
    idleCycle(1'b1);
    @(negedge HCLK);
    checkOutput({tag, "_req_drop"}, {63'd0, sram_req}, 64'd0);
    checkOutput({tag, "_words"},    {48'd0, o_words_written}, 64'd1);
    checkOutput({tag, "_empty"},    {63'd0, o_empty}, 64'd1);
  endtask

  initial begin
    HRESETn        = 1'b0;
    mem_write_flag = 1'b0;
    mem_WR_addr    = '0;
    HWDATA_toMem   = '0;
    sram_gnt       = 1'b0;
    i_clr          = 1'b0;

    // Reset values
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    checkOutput("rst_req",   {63'd0, sram_req},   64'd0);
    checkOutput("rst_empty", {63'd0, o_empty},    64'd1);
    checkOutput("rst_full",  {63'd0, o_full},     64'd0);
    checkOutput("rst_level", {60'd0, o_level},    64'd0);
    checkOutput("rst_ovf",   {63'd0, o_overflow}, 64'd0);
    checkOutput("rst_words", {48'd0, o_words_written}, 64'd0);
    checkOutput("rst_addr",  {32'd0, sram_addr},  64'd0);
    checkOutput("rst_wdata", {32'd0, sram_wdata}, 64'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    $display("[TB] single write");
    singleWrite("single");

    $display("[TB] back-pressure");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'h0000_1000 + 32'(4 * i), 32'(i), 1'b0, 1'b0);
    end
    idleCycle(1'b0);
    @(negedge HCLK);
    checkOutput("bp_full",  {63'd0, o_full},  64'd1);
    checkOutput("bp_level", {60'd0, o_level}, 64'd8);
    checkOutput("bp_head",  {32'd0, sram_wdata}, 64'd0);
    idleCycle(1'b0);
    @(negedge HCLK);
    checkOutput("bp_head_stable", {32'd0, sram_wdata}, 64'd0);
    checkOutput("bp_addr_stable", {32'd0, sram_addr},  64'h0000_1000);

    $display("[TB] overflow");
    applyStimulus(1'b1, 32'h0000_9990, 32'h99, 1'b0, 1'b0);
    idleCycle(1'b0);
    @(negedge HCLK);
    checkOutput("ovf_set",   {63'd0, o_overflow}, 64'd1);
    checkOutput("ovf_level", {60'd0, o_level},    64'd8);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idleCycle(1'b0);
    @(negedge HCLK);
    checkOutput("clr_ovf",   {63'd0, o_overflow}, 64'd0);
    checkOutput("clr_words", {48'd0, o_words_written}, 64'd0);
    checkOutput("clr_level", {60'd0, o_level},    64'd8);

    $display("[TB] push and pop at full");
    applyStimulus(1'b1, 32'h0000_2000, 32'hAA, 1'b1, 1'b0);
    idleCycle(1'b0);
    @(negedge HCLK);
    checkOutput("pp_full_level", {60'd0, o_level},    64'd8);
    checkOutput("pp_full_ovf",   {63'd0, o_overflow}, 64'd0);
    checkOutput("pp_full_head",  {32'd0, sram_wdata}, 64'd1);
    repeat (DEPTH) idleCycle(1'b1);
    idleCycle(1'b0);
    @(negedge HCLK);
    checkOutput("pp_full_drained", {63'd0, o_empty}, 64'd1);
    checkOutput("pp_full_words",   {48'd0, o_words_written}, 64'd9);

    $display("[TB] push and pop at one entry");
    applyStimulus(1'b1, 32'h0000_2100, 32'h55, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_2104, 32'h66, 1'b1, 1'b0);
    idleCycle(1'b0);
    @(negedge HCLK);
    checkOutput("pp_one_level", {60'd0, o_level},    64'd1);
    checkOutput("pp_one_head",  {32'd0, sram_wdata}, 64'h66);
    idleCycle(1'b1);
    idleCycle(1'b0);
    @(negedge HCLK);
    checkOutput("pp_one_empty", {63'd0, o_empty}, 64'd1);

    // Two bursts of ten at one write per cycle with grant toggling keeps the
    // peak occupancy below DEPTH while still carrying the pointers around.
    $display("[TB] pointer wrap");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 10; i++) begin
        applyStimulus(1'b1, 32'h0000_3000 + 32'(4 * (10 * b + i)),
                      32'h100 + 32'(10 * b + i), (i % 2) == 0, 1'b0);
      end
      repeat (10) idleCycle(1'b1);
    end
    idleCycle(1'b0);
    @(negedge HCLK);
    checkOutput("wrap_words", {48'd0, o_words_written}, 64'd20);
    checkOutput("wrap_empty", {63'd0, o_empty}, 64'd1);
    checkOutput("wrap_sb_empty", 64'(sbQueue.size()), 64'd0);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h0000_4000 + 32'(4 * i), 32'h200 + 32'(i), 1'b0, 1'b0);
    end
    idleCycle(1'b0);
    @(negedge HCLK);
    checkOutput("mid_level_before", {60'd0, o_level}, 64'd5);
    @(posedge HCLK);
    #3;
    HRESETn = 1'b0;
    #1;
    checkOutput("mid_rst_req",   {63'd0, sram_req}, 64'd0);
    checkOutput("mid_rst_level", {60'd0, o_level},  64'd0);
    checkOutput("mid_rst_empty", {63'd0, o_empty},  64'd1);
    checkOutput("mid_rst_addr",  {32'd0, sram_addr}, 64'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    singleWrite("after_rst");

    repeat (2) idleCycle(1'b1);
    @(negedge HCLK);
    checkOutput("final_sb_empty", 64'(sbQueue.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Buffers the word writes produced by the AHB DMA slave's memory-write port (`mem_WR_addr`, `mem_write_flag`, `HWDATA_toMem`) and drains them to the SRAM over a request/grant handshake. It absorbs SRAM stalls during bursts. It reports fill level, full/empty, sticky overflow and a count of retired writes. It sits directly downstream of `CPU_DMA_slave`, between the AHB fabric and the memory macro.

## Interface

**Parameters**
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.

**Ports**
- Clock and reset: one clock, `HCLK`; reset `HRESETn` is asynchronous and active-low.
- `HCLK`  in  1  clock; all state updates on its rising edge.
- `HRESETn`  in  1  asynchronous active-low reset.
- `mem_WR_addr`  in  ADDR_W  write address from slave.
- `mem_write_flag`  in  1  write strobe; one write per high cycle.
- `HWDATA_toMem`  in  DATA_W  write data from slave.
- `sram_req`  out  1  head entry valid toward SRAM.
- `sram_addr`  out  ADDR_W  head entry address.
- `sram_wdata`  out  DATA_W  head entry data.
- `sram_gnt`  in  1  SRAM accepts head entry this cycle.
- `i_clr`  in  1  synchronous clear of `o_overflow` and `o_words_written`.
- `o_level`  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- `o_full`  out  1  `o_level == DEPTH`.
- `o_empty`  out  1  `o_level == 0`.
- `o_overflow`  out  1  sticky; a write was dropped.
- `o_words_written`  out  16  writes retired to SRAM.

## Operation

- Storage: circular array of {addr, data}, `DEPTH` entries.
  - Pointers `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Level is held in a separate counter.
- Push: `mem_write_flag && (!o_full || pop)`. Store at `wr_ptr`, then increment `wr_ptr`.
- Pop: `sram_req && sram_gnt`. Increment `rd_ptr`.
- Level update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, including at full and at one entry.
- Drop: `mem_write_flag && o_full && !pop`.
  - The entry is discarded and the array is unchanged.
  - `o_overflow` is set on the next edge.
- No write-through: a push into an empty FIFO appears on `sram_req` the cycle after the push edge, not in the same cycle.
- SRAM side:
  - `sram_req = !o_empty`.
  - `sram_addr` and `sram_wdata` are driven combinationally from the array at `rd_ptr`.
  - All three are stable while `sram_req && !sram_gnt`.
  - `sram_gnt` while `sram_req` is low is ignored.
- Retired-write counter:
  - `o_words_written` increments on each pop.
  - It wraps from 0xFFFF to 0x0000 and sets no flag.
- `i_clr`:
  - Zeroes `o_overflow` and `o_words_written` at the next edge.
  - Clear takes priority over a same-cycle set or increment.
  - FIFO contents are not affected.
- Addresses and data pass through unmodified. No alignment check.

## Timing

- Reset (async assert, sync-to-edge deassert use by surrounding logic):
  - Pointers and level are 0.
  - `o_empty` = 1; `o_full` = 0; `sram_req` = 0.
  - `o_overflow` = 0; `o_words_written` = 0.
  - `sram_addr` and `sram_wdata` are 0; array contents are don't-care.
- Reset asserted mid-burst: all queued entries are lost and the outputs above take their reset values immediately, without waiting for a clock edge.
- Latency:
  - Push edge to `sram_req` high: 1 cycle.
  - With `sram_gnt` held high, throughput is one write per cycle and the level stays constant.
- Flags and level are registered-state derived and valid the cycle after the causing edge.
- Ordering: strictly FIFO. SRAM sees writes in arrival order with no reorder and no merge.

## Test plan

- Single write, grant held high:
  - Stimulus: push addr 0x0000_0100 / data 0xDEAD_BEEF.
  - Response: `sram_req` high for exactly 1 cycle, one cycle after the push, carrying that pair.
  - `o_words_written` = 1; `o_empty` returns to 1.
- Back-pressure with `DEPTH`=8 and `sram_gnt`=0:
  - Stimulus: 8 pushes with data 0..7.
  - Response: `o_full` = 1 and `o_level` = 8; head holds data 0, stable.
  - Stimulus: release grant.
  - Response: data 0..7 emerge in order over 8 cycles.
- Overflow:
  - Stimulus: from full with grant low, push data 0x99.
  - Response: `o_overflow` = 1, `o_level` stays 8, and data 0x99 never appears at the SRAM.
  - Stimulus: pulse `i_clr`.
  - Response: `o_overflow` = 0, `o_words_written` = 0, and the 8 entries are still present.
- Simultaneous push and pop:
  - At full: push 0xAA while granting the head. Level stays 8, no overflow, and 0xAA drains last.
  - At level 1: same result with level staying 1.
- Pointer wrap:
  - Stimulus: 20 writes at a steady 1/cycle with grant toggling 1-0-1-0.
  - Response: all 20 retire in order and `o_words_written` = 20.
- Reset mid-operation:
  - Stimulus: assert `HRESETn`=0 asynchronously between edges with 5 entries queued.
  - Response: `sram_req` = 0, `o_level` = 0 and `o_empty` = 1 before the next edge.
  - After release, the next push behaves as the single-write case.
